systolic_result_drain: RTL and testbench

- Consumes the row-major result stream leaving the systolic array and writes each beat into result memory at its (row, column) address.
- Regenerates the column/row indices on the consumer side, mirroring the feed-side scan counter.
- Adds valid/ready backpressure, a one-entry output register, and a frame-done pulse for the controller.

---
 rtl/systolic_pkg.sv | 25 ++
 rtl/drain_index_gen.sv | 86 ++++++++
 rtl/systolic_result_drain.sv | 137 +++++++++++++
 tb/tb_systolic_result_drain.sv | 315 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/systolic_pkg.sv
// Shared definitions for the systolic result drain.
//   drain_state_t : drain controller states (IDLE, DRAIN, FLUSH).
//   idx_w()       : counter width for a dimension. It never returns less
//                   than 1, so a dimension of size 1 still has a legal
//                   (constant-zero) index signal.
//   DEF_*         : default frame geometry and the widths derived from it.
package systolic_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DRAIN = 2'd1,
    FLUSH = 2'd2
  } drain_state_t;

  function automatic int unsigned idx_w(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  localparam int unsigned DEF_WIDTH  = 32;
  localparam int unsigned DEF_HEIGHT = 32;
  localparam int unsigned DEF_COL_W  = idx_w(DEF_WIDTH);
  localparam int unsigned DEF_ROW_W  = idx_w(DEF_HEIGHT);
  localparam int unsigned DEF_ADDR_W = idx_w(DEF_WIDTH * DEF_HEIGHT);

endpackage

// File: rtl/drain_index_gen.sv
// Consumer-side scan counter for the result drain. It mirrors the feed-side
// scan: col runs 0..WIDTH-1, then wraps and row advances; the address counter
// is maintained incrementally alongside, without a multiplier.
// Build option RESULT_DRAIN_TRANSPOSE_EN selects a column-major address
// (col*HEIGHT + row) instead of row-major (row*WIDTH + col).
// Ports:
//   clk, rst   : clock, synchronous active-high reset
//   clear      : restart the scan at (0,0), address 0
//   advance    : step to the next beat
//   col, row   : indices of the current (next-to-accept) beat
//   addr       : result-memory address of the current beat
//   last       : current beat is the final one of the frame
module drain_index_gen
  import systolic_pkg::*;
#(
  parameter  int unsigned WIDTH  = DEF_WIDTH,
  parameter  int unsigned HEIGHT = DEF_HEIGHT,
  localparam int unsigned COL_W  = idx_w(WIDTH),
  localparam int unsigned ROW_W  = idx_w(HEIGHT),
  localparam int unsigned ADDR_W = idx_w(WIDTH * HEIGHT)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clear,
  input  logic              advance,
  output logic [COL_W-1:0]  col,
  output logic [ROW_W-1:0]  row,
  output logic [ADDR_W-1:0] addr,
  output logic              last
);

  logic [COL_W-1:0]  col_q,  col_d;
  logic [ROW_W-1:0]  row_q,  row_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic              col_end, row_end;

  assign col_end = (col_q == COL_W'(WIDTH - 1));
  assign row_end = (row_q == ROW_W'(HEIGHT - 1));

  always_comb begin
    col_d  = col_q;
    row_d  = row_q;
    addr_d = addr_q;
    if (clear) begin
      col_d  = '0;
      row_d  = '0;
      addr_d = '0;
    end else if (advance) begin
      if (col_end) begin
        col_d = '0;
        row_d = row_end ? '0 : row_q + ROW_W'(1);
      end else begin
        col_d = col_q + COL_W'(1);
      end
`ifdef RESULT_DRAIN_TRANSPOSE_EN
      // Column-major: stride HEIGHT along a row; at a row end the next row
      // starts at address row+1 (its column-0 slot).
      if (col_end) begin
        addr_d = row_end ? '0 : ADDR_W'(row_q) + ADDR_W'(1);
      end else begin
        addr_d = addr_q + ADDR_W'(HEIGHT);
      end
`else
      addr_d = (col_end && row_end) ? '0 : addr_q + ADDR_W'(1);
`endif
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      col_q  <= '0;
      row_q  <= '0;
      addr_q <= '0;
    end else begin
      col_q  <= col_d;
      row_q  <= row_d;
      addr_q <= addr_d;
    end
  end

  assign col  = col_q;
  assign row  = row_q;
  assign addr = addr_q;
  assign last = col_end && row_end;

endmodule

// File: rtl/systolic_result_drain.sv
// Drains the row-major result stream leaving the systolic array into result
// memory. Each accepted beat is written at its (row, col) address one cycle
// later through a one-entry output register that holds while memory stalls.
// A frame is armed by start; after the last beat's write is taken by memory,
// frame_done pulses for one cycle and the block returns to IDLE.
// Build option RESULT_DRAIN_TRANSPOSE_EN: column-major memory layout.
// Ports:
//   clk, rst                     : clock, synchronous active-high reset
//   start                        : arm a frame (ignored unless IDLE)
//   in_valid/in_ready/in_data    : result beat handshake
//   mem_we/mem_addr/mem_wdata    : memory write request, held until mem_ready
//   mem_ready                    : memory takes the write this cycle
//   col_idx/row_idx              : indices of the next beat to accept
//   busy                         : frame in progress (DRAIN or FLUSH)
//   frame_done                   : one-cycle pulse after the final write
module systolic_result_drain
  import systolic_pkg::*;
#(
  parameter  int unsigned WIDTH  = DEF_WIDTH,
  parameter  int unsigned HEIGHT = DEF_HEIGHT,
  parameter  int unsigned DATA_W = 32,
  localparam int unsigned COL_W  = idx_w(WIDTH),
  localparam int unsigned ROW_W  = idx_w(HEIGHT),
  localparam int unsigned ADDR_W = idx_w(WIDTH * HEIGHT)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic              mem_ready,
  output logic [COL_W-1:0]  col_idx,
  output logic [ROW_W-1:0]  row_idx,
  output logic              busy,
  output logic              frame_done
);

  drain_state_t      state_q, state_d;
  logic              mem_we_q, mem_we_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
  logic              frame_done_q, frame_done_d;

  logic              in_ready_c;
  logic              accept;
  logic              idx_clear;
  logic [ADDR_W-1:0] idx_addr;
  logic              idx_last;

  drain_index_gen #(
    .WIDTH  (WIDTH),
    .HEIGHT (HEIGHT)
  ) u_index (
    .clk     (clk),
    .rst     (rst),
    .clear   (idx_clear),
    .advance (accept),
    .col     (col_idx),
    .row     (row_idx),
    .addr    (idx_addr),
    .last    (idx_last)
  );

  always_comb begin
    state_d      = state_q;
    mem_we_d     = mem_we_q;
    mem_addr_d   = mem_addr_q;
    mem_wdata_d  = mem_wdata_q;
    frame_done_d = 1'b0;
    in_ready_c   = 1'b0;
    accept       = 1'b0;
    idx_clear    = 1'b0;

    case (state_q)
      IDLE: begin
        if (start) begin
          state_d   = DRAIN;
          idx_clear = 1'b1;
        end
      end
      DRAIN: begin
        // The output register frees up in the same cycle memory takes it,
        // so a write and the next accept can overlap.
        in_ready_c = !mem_we_q || mem_ready;
        accept     = in_valid && in_ready_c;
        if (accept && idx_last) begin
          state_d = FLUSH;
        end
      end
      FLUSH: begin
        if (mem_we_q && mem_ready) begin
          state_d      = IDLE;
          frame_done_d = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase

    if (mem_we_q && mem_ready) begin
      mem_we_d = 1'b0;
    end
    // A new accept refills the register, overriding the retire above.
    if (accept) begin
      mem_we_d    = 1'b1;
      mem_addr_d  = idx_addr;
      mem_wdata_d = in_data;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      mem_we_q     <= 1'b0;
      mem_addr_q   <= '0;
      mem_wdata_q  <= '0;
      frame_done_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      mem_we_q     <= mem_we_d;
      mem_addr_q   <= mem_addr_d;
      mem_wdata_q  <= mem_wdata_d;
      frame_done_q <= frame_done_d;
    end
  end

  assign in_ready   = in_ready_c;
  assign mem_we     = mem_we_q;
  assign mem_addr   = mem_addr_q;
  assign mem_wdata  = mem_wdata_q;
  assign busy       = (state_q != IDLE);
  assign frame_done = frame_done_q;

endmodule

// File: tb/tb_systolic_result_drain.sv
// Bench for systolic_result_drain: a 4x2 instance exercised by a table of
// per-cycle vectors, directed stall / reset sequences and randomized traffic
// checked against a transaction-level model, plus a 1x1 instance.
module tb_systolic_result_drain;

  localparam int W = 4;
  localparam int H = 2;
  localparam int N = W * H;

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, start, in_valid, mem_ready;
  logic [31:0] in_data;
  logic        in_ready, mem_we, busy, frame_done;
  logic [2:0]  mem_addr;
  logic [31:0] mem_wdata;
  logic [1:0]  col_idx;
  logic [0:0]  row_idx;

  logic        s_start, s_in_valid, s_mem_ready;
  logic [31:0] s_in_data;
  logic        s_in_ready, s_mem_we, s_busy, s_frame_done;
  logic [0:0]  s_mem_addr;
  logic [31:0] s_mem_wdata;
  logic [0:0]  s_col_idx, s_row_idx;

  systolic_result_drain #(.WIDTH(W), .HEIGHT(H), .DATA_W(32)) u_dut (
    .clk(clk), .rst(rst), .start(start), .in_valid(in_valid),
    .in_ready(in_ready), .in_data(in_data), .mem_we(mem_we),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_ready(mem_ready),
    .col_idx(col_idx), .row_idx(row_idx), .busy(busy),
    .frame_done(frame_done)
  );

  systolic_result_drain #(.WIDTH(1), .HEIGHT(1), .DATA_W(32)) u_dut1 (
    .clk(clk), .rst(rst), .start(s_start), .in_valid(s_in_valid),
    .in_ready(s_in_ready), .in_data(s_in_data), .mem_we(s_mem_we),
    .mem_addr(s_mem_addr), .mem_wdata(s_mem_wdata), .mem_ready(s_mem_ready),
    .col_idx(s_col_idx), .row_idx(s_row_idx), .busy(s_busy),
    .frame_done(s_frame_done)
  );

  int vectors = 0;
  int miscompares = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
    end
  endtask

  // Memory address of the k-th beat of a frame (k in scan order).
  function automatic int addr_of(input int k);
    int r;
    int c;
    r = k / W;
    c = k % W;
`ifdef RESULT_DRAIN_TRANSPOSE_EN
    return c * H + r;
`else
    return r * W + c;
`endif
  endfunction

  // Transaction-level model: beats accepted, writes retired, one pending write.
  bit          m_active, m_pend, m_done;
  int          m_acc, m_wr;
  logic [31:0] m_paddr, m_pdata;
  int          dut_writes;

  task automatic model_reset(input int acc);
    m_active = 0; m_pend = 0; m_done = 0;
    m_acc = acc; m_wr = acc;
  endtask

  // Called at the negedge: compares DUT against the model, then advances the
  // model by the transfers that will happen at the coming posedge.
  task automatic model_check();
    bit exp_rdy;
    bit was_active;
    int nxt;
    exp_rdy = m_active && (m_acc < N) && (!m_pend || mem_ready);
    chk("in_ready", in_ready, exp_rdy);
    chk("mem_we", mem_we, m_pend);
    if (m_pend) begin
      chk("mem_addr", mem_addr, m_paddr);
      chk("mem_wdata", mem_wdata, m_pdata);
    end
    chk("busy", busy, m_active);
    chk("frame_done", frame_done, m_done);
    nxt = m_acc % N;
    chk("col_idx", col_idx, nxt % W);
    chk("row_idx", row_idx, nxt / W);
    if (mem_we && mem_ready) dut_writes++;

    was_active = m_active;
    m_done = 0;
    if (m_pend && mem_ready) begin
      m_pend = 0;
      m_wr++;
      if (m_wr == N) begin
        m_active = 0;
        m_done = 1;
      end
    end
    if (exp_rdy && in_valid) begin
      m_pend  = 1;
      m_paddr = addr_of(m_acc);
      m_pdata = in_data;
      m_acc++;
    end
    if (!was_active && start) begin
      m_active = 1;
      m_acc = 0;
      m_wr = 0;
    end
  endtask

  task automatic tick();
    @(negedge clk);
    model_check();
    @(posedge clk);
    #1;
  endtask

  task automatic finish_frame(input string name);
    int guard;
    guard = 0;
    start = 0; in_valid = 1; mem_ready = 1;
    while ((m_active || m_done) && guard < 40) begin
      in_data = $urandom;
      tick();
      guard++;
    end
    if (guard >= 40) chk({name, "_timeout"}, 0, 1);
  endtask

  task automatic chk_reset_outputs(input string name);
    chk({name, "_in_ready"}, in_ready, 0);
    chk({name, "_mem_we"}, mem_we, 0);
    chk({name, "_mem_addr"}, mem_addr, 0);
    chk({name, "_mem_wdata"}, mem_wdata, 0);
    chk({name, "_col"}, col_idx, 0);
    chk({name, "_row"}, row_idx, 0);
    chk({name, "_busy"}, busy, 0);
    chk({name, "_done"}, frame_done, 0);
  endtask

  typedef struct {
    logic        start, in_valid, mem_ready;
    logic [31:0] in_data;
    logic        exp_rdy, exp_we;
    logic [2:0]  exp_addr;
    logic [31:0] exp_wdata;
    logic        exp_busy, exp_done;
  } vec_t;

  vec_t tbl [12];

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [2:0]  held_a;
    logic [31:0] held_d;
    int          guard;

    // Full-frame table, mem_ready=1 and in_valid=1 throughout:
    // start in cycle 0, beats accepted in cycles 1..8, writes 2..9, done in 10.
    for (int c = 0; c < 12; c++) begin
      tbl[c].start     = (c == 0);
      tbl[c].in_valid  = 1'b1;
      tbl[c].mem_ready = 1'b1;
      tbl[c].in_data   = 32'hD000 + c;
      tbl[c].exp_rdy   = (c >= 1 && c <= 8);
      tbl[c].exp_we    = (c >= 2 && c <= 9);
      tbl[c].exp_addr  = (c >= 2 && c <= 9) ? 3'(addr_of(c - 2)) : 3'd0;
      tbl[c].exp_wdata = 32'hD000 + c - 1;
      tbl[c].exp_busy  = (c >= 1 && c <= 9);
      tbl[c].exp_done  = (c == 10);
    end

    rst = 1; start = 0; in_valid = 0; mem_ready = 0; in_data = '0;
    s_start = 0; s_in_valid = 0; s_mem_ready = 0; s_in_data = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk_reset_outputs("reset");
    chk("reset1_busy", s_busy, 0);
    chk("reset1_mem_we", s_mem_we, 0);
    @(posedge clk); #1;
    rst = 0;
    model_reset(0);

    // Table-driven full frame
    for (int c = 0; c < 12; c++) begin
      start = tbl[c].start; in_valid = tbl[c].in_valid;
      mem_ready = tbl[c].mem_ready; in_data = tbl[c].in_data;
      @(negedge clk);
      chk($sformatf("tbl%0d_in_ready", c), in_ready, tbl[c].exp_rdy);
      chk($sformatf("tbl%0d_mem_we", c), mem_we, tbl[c].exp_we);
      if (tbl[c].exp_we) begin
        chk($sformatf("tbl%0d_mem_addr", c), mem_addr, tbl[c].exp_addr);
        chk($sformatf("tbl%0d_mem_wdata", c), mem_wdata, tbl[c].exp_wdata);
      end
      chk($sformatf("tbl%0d_busy", c), busy, tbl[c].exp_busy);
      chk($sformatf("tbl%0d_done", c), frame_done, tbl[c].exp_done);
      @(posedge clk); #1;
    end
    model_reset(N);

    // Stall on the 3rd write for 3 cycles, with a stray start mid-frame
    dut_writes = 0;
    start = 1; in_valid = 1; mem_ready = 1; in_data = $urandom;
    tick();
    start = 0;
    guard = 0;
    while (!(m_pend && m_paddr == 32'(addr_of(2))) && guard < 20) begin
      in_data = $urandom;
      tick();
      guard++;
    end
    if (guard >= 20) chk("stall_reach", 0, 1);
    held_a = m_paddr[2:0];
    held_d = m_pdata;
    mem_ready = 0;
    for (int s = 0; s < 3; s++) begin
      in_data = $urandom;
      start = (s == 0);
      @(negedge clk);
      chk("stall_addr", mem_addr, held_a);
      chk("stall_wdata", mem_wdata, held_d);
      chk("stall_in_ready", in_ready, 0);
      model_check();
      @(posedge clk); #1;
    end
    start = 0;
    finish_frame("stall");
    chk("stall_write_count", dut_writes, N);

    // Reset after 5 beats, then a fresh frame
    start = 1; in_valid = 1; mem_ready = 1; in_data = $urandom;
    tick();
    start = 0;
    guard = 0;
    while (m_acc < 5 && guard < 20) begin
      in_data = $urandom;
      tick();
      guard++;
    end
    rst = 1; start = 1;
    @(posedge clk); #1;
    rst = 0; start = 0; in_valid = 0;
    @(negedge clk);
    chk_reset_outputs("midrst");
    model_reset(0);
    @(posedge clk); #1;
    dut_writes = 0;
    in_valid = 1; tick();              // in_valid in IDLE: must be ignored
    start = 1; in_data = $urandom; tick();
    finish_frame("fresh");
    chk("fresh_write_count", dut_writes, N);

    // Randomized traffic with stray starts and idle-time in_valid
    for (int it = 0; it < 500; it++) begin
      if (!m_active && !m_done) start = ($urandom % 4 == 0);
      else start = ($urandom % 16 == 0);
      in_valid  = ($urandom % 10) < 7;
      mem_ready = ($urandom % 10) < 7;
      in_data   = $urandom;
      tick();
    end
    finish_frame("random");

    // 1x1 frame on the second instance
    in_valid = 0; mem_ready = 0;
    s_start = 1; s_in_valid = 1; s_in_data = 32'h55; s_mem_ready = 1;
    @(negedge clk);
    chk("one_idle_ready", s_in_ready, 0);
    chk("one_idle_busy", s_busy, 0);
    @(posedge clk); #1;
    s_start = 0;
    @(negedge clk);
    chk("one_ready", s_in_ready, 1);
    chk("one_col", s_col_idx, 0);
    chk("one_row", s_row_idx, 0);
    chk("one_busy", s_busy, 1);
    @(posedge clk); #1;
    s_in_valid = 0;
    @(negedge clk);
    chk("one_we", s_mem_we, 1);
    chk("one_addr", s_mem_addr, 0);
    chk("one_wdata", s_mem_wdata, 32'h55);
    chk("one_flush_ready", s_in_ready, 0);
    chk("one_flush_busy", s_busy, 1);
    @(posedge clk); #1;
    @(negedge clk);
    chk("one_done", s_frame_done, 1);
    chk("one_done_busy", s_busy, 0);
    chk("one_done_we", s_mem_we, 0);
    @(posedge clk); #1;
    @(negedge clk);
    chk("one_done_clear", s_frame_done, 0);
    chk("one_end_busy", s_busy, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
